// File: rtl/dff_checker_pkg.sv
// Package: dff_checker_pkg
// Shared definitions for the D flip-flop pattern checker:
//   state_t          checker FSM states
//   LFSR_TAPS        tap mask of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
//   DEFAULT_CNT_W    default width of the test/pass counters
//   DEFAULT_LATENCY  default number of cycles D is held before Q is sampled
//   lfsr_next()      one shift of the pattern LFSR
package dff_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS       = 8'b1011_1000;
    localparam int         DEFAULT_CNT_W   = 8;
    localparam int         DEFAULT_LATENCY = 2;

    // Shift left; the feedback (XOR of bits 7,5,4,3) enters at bit 0,
    // so bit 0 always holds the most recently generated pattern bit.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dff_checker_lfsr.sv
// Module: dff_checker_lfsr
// 8-bit Fibonacci LFSR that produces the pseudo-random D pattern.
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous active-high reset (state returns to SEED)
//   load     in   1  reload SEED (start of a run)
//   advance  in   1  step the LFSR once (end of each check)
//   state    out  8  current LFSR contents
module dff_checker_lfsr
    import dff_checker_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] state
);

    // An all-zero LFSR never leaves zero, so such a seed is rejected.
    if (SEED == 8'h00) begin : g_bad_seed
        $error("dff_checker_lfsr: SEED must be non-zero");
    end

    // Load has priority so a restart always begins from the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/dff_pattern_checker.sv
// Module: dff_pattern_checker
// On-chip stimulus/checker for a single D flip-flop. Drives D with a bit
// pattern, waits LATENCY cycles, then checks Q against the driven bit and
// Q-bar against ~Q. One check takes LATENCY+2 cycles; a run is NUM_TESTS checks.
// Optional feature macro: DFF_CHECKER_LFSR_EN
//   defined   -> pattern bit is bit 0 of an 8-bit LFSR seeded with SEED
//   undefined -> pattern bit alternates 0,1,0,1,... (SEED unused)
// Ports:
//   input_clock1_1          in   1      clock, rising edge
//   input_reset1_2          in   1      asynchronous active-high reset
//   input_start_3           in   1      start/restart, honoured in IDLE or DONE
//   input_q_4               in   1      Q from the flip-flop under test
//   input_qn_5              in   1      Q-bar from the flip-flop under test
//   output_d_0_6            out  1      registered D to the flip-flop under test
//   output_busy_0_7         out  1      run in progress
//   output_done_0_8         out  1      run finished, held until start/reset
//   output_pass_0_9         out  1      done with no failed check
//   output_test_count_0_10  out  CNT_W  checks performed this run
//   output_pass_count_0_11  out  CNT_W  checks passed this run
//   output_fail_0_12        out  1      sticky: some check failed this run
module dff_pattern_checker
    import dff_checker_pkg::*;
#(
    parameter int         NUM_TESTS = 8,
    parameter int         CNT_W     = DEFAULT_CNT_W,
    parameter int         LATENCY   = DEFAULT_LATENCY,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic             input_clock1_1,
    input  logic             input_reset1_2,
    input  logic             input_start_3,
    input  logic             input_q_4,
    input  logic             input_qn_5,
    output logic             output_d_0_6,
    output logic             output_busy_0_7,
    output logic             output_done_0_8,
    output logic             output_pass_0_9,
    output logic [CNT_W-1:0] output_test_count_0_10,
    output logic [CNT_W-1:0] output_pass_count_0_11,
    output logic             output_fail_0_12
);

    localparam int WAIT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dff_pattern_checker: LATENCY must be >= 1");
    end
    if (NUM_TESTS < 1 || NUM_TESTS > (1 << CNT_W) - 1) begin : g_bad_num_tests
        $error("dff_pattern_checker: NUM_TESTS must be in 1..2**CNT_W-1");
    end

    logic clk;
    logic rst;
    assign clk = input_clock1_1;
    assign rst = input_reset1_2;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   test_count;
    logic [CNT_W-1:0]   pass_count;
    logic               fail;
    logic               d_reg;
    logic               exp_bit;
    logic               next_bit;
    logic               start_run;
    logic               drive_exit;
    logic               check_exit;
    logic               check_ok;

`ifdef DFF_CHECKER_LFSR_EN
    logic [7:0] lfsr_state;

    dff_checker_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (start_run),
        .advance (check_exit),
        .state   (lfsr_state)
    );

    // The pattern bit is the LFSR's LSB.
    assign next_bit = ^(lfsr_state & 8'b0000_0001);
`else
    // Only the LSB of the step index shapes the alternating pattern, so a
    // single toggling bit stands in for the whole index.
    logic step_lsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_lsb <= 1'b0;
        end else if (start_run) begin
            step_lsb <= 1'b0;
        end else if (check_exit) begin
            step_lsb <= ~step_lsb;
        end
    end

    assign next_bit = step_lsb;

    // SEED only matters to the LFSR build.
    if (SEED == 8'h00) begin : g_seed_ignored
    end
`endif

    // Exact (===) comparison so an X or Z on Q or Q-bar is a failure.
    assign check_ok = (input_q_4 === exp_bit) && (input_qn_5 === ~input_q_4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the one-cycle strobes the datapath acts on.
    // A start outside IDLE/DONE falls through untouched, so it is ignored.
    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        drive_exit = 1'b0;
        check_exit = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (input_start_3) begin
                    start_run  = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                drive_exit = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_W'(1)) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                check_exit = 1'b1;
                if (test_count == CNT_W'(NUM_TESTS - 1)) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: D/expected bit, wait countdown, and the per-run scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg      <= 1'b0;
            exp_bit    <= 1'b0;
            wait_cnt   <= '0;
            test_count <= '0;
            pass_count <= '0;
            fail       <= 1'b0;
        end else begin
            if (start_run) begin
                test_count <= '0;
                pass_count <= '0;
                fail       <= 1'b0;
            end
            if (drive_exit) begin
                d_reg    <= next_bit;
                exp_bit  <= next_bit;
                wait_cnt <= WAIT_W'(LATENCY);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (check_exit) begin
                test_count <= test_count + CNT_W'(1);
                if (check_ok) begin
                    pass_count <= pass_count + CNT_W'(1);
                end else begin
                    fail <= 1'b1;
                end
            end
        end
    end

    assign output_d_0_6           = d_reg;
    assign output_busy_0_7        = (state == DRIVE) || (state == WAIT) || (state == CHECK);
    assign output_done_0_8        = (state == DONE);
    assign output_pass_0_9        = (state == DONE) && !fail;
    assign output_test_count_0_10 = test_count;
    assign output_pass_count_0_11 = pass_count;
    assign output_fail_0_12       = fail;

endmodule

// File: tb/tb_dff_pattern_checker.sv
// Testbench: tb_dff_pattern_checker
// Pairs dff_pattern_checker with a behavioural D flip-flop whose Q/Q-bar can
// be faulted (stuck-at-0, stuck-at-1, Q-bar tied to Q). Expected D bits and
// pass counts come from a behavioural pattern model; a table of whole-run
// results, hand-written reset/restart sequences and randomized runs follow.
module tb_dff_pattern_checker;

    localparam int         NUM_TESTS = 8;
    localparam int         CNT_W     = 8;
    localparam int         LATENCY   = 2;
    localparam int         STEP      = LATENCY + 2;
    localparam logic [7:0] SEED      = 8'hA5;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             q;
    logic             qn;
    logic             d;
    logic             busy;
    logic             done;
    logic             pass_out;
    logic [CNT_W-1:0] test_count;
    logic [CNT_W-1:0] pass_count;
    logic             fail;

    int   mode = 0;
    logic q_ff;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int    mode;
        int    exp_pass;
        int    exp_fail;
        string name;
    } vec_t;

    vec_t vecs[4];

    dff_pattern_checker #(
        .NUM_TESTS (NUM_TESTS),
        .CNT_W     (CNT_W),
        .LATENCY   (LATENCY),
        .SEED      (SEED)
    ) dut (
        .input_clock1_1         (clock),
        .input_reset1_2         (reset),
        .input_start_3          (start),
        .input_q_4              (q),
        .input_qn_5             (qn),
        .output_d_0_6           (d),
        .output_busy_0_7        (busy),
        .output_done_0_8        (done),
        .output_pass_0_9        (pass_out),
        .output_test_count_0_10 (test_count),
        .output_pass_count_0_11 (pass_count),
        .output_fail_0_12       (fail)
    );

    always #5 clock = ~clock;

    // Ideal flip-flop under test.
    always @(posedge clock or posedge reset) begin
        if (reset) q_ff <= 1'b0;
        else       q_ff <= d;
    end

    // Fault injection: 0 ideal, 1 Q stuck at 0, 2 Q stuck at 1, 3 Q-bar equal to Q.
    always_comb begin
        q  = q_ff;
        qn = ~q_ff;
        case (mode)
            1: begin q = 1'b0; qn = 1'b1; end
            2: begin q = 1'b1; qn = 1'b0; end
            3: begin q = q_ff; qn = q_ff; end
            default: ;
        endcase
    end

    // Pattern bit driven for check k.
    function automatic int model_bit(input int k);
`ifdef DFF_CHECKER_LFSR_EN
        int s;
        s = int'(SEED);
        for (int i = 0; i < k; i++) begin
            int fb;
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s << 1) | fb) & 255;
        end
        return s & 1;
`else
        return k % 2;
`endif
    endfunction

    // Whether a check on pattern bit b passes under the given fault mode.
    function automatic int model_ok(input int m, input int b);
        case (m)
            0:       return 1;
            1:       return (b == 0) ? 1 : 0;
            2:       return (b == 1) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdleReset(input string tag);
        checkOutput({tag, " d"},          int'(d),          0);
        checkOutput({tag, " busy"},       int'(busy),       0);
        checkOutput({tag, " done"},       int'(done),       0);
        checkOutput({tag, " pass_out"},   int'(pass_out),   0);
        checkOutput({tag, " test_count"}, int'(test_count), 0);
        checkOutput({tag, " pass_count"}, int'(pass_count), 0);
        checkOutput({tag, " fail"},       int'(fail),       0);
    endtask

    // Run one complete test sequence from a start pulse, checking every cycle
    // against the model. inject_at > 0 pulses start again on that edge of the run.
    task automatic applyStimulus(input int m, input int inject_at, input string tag,
                                 output int exp_pass);
        int cyc;
        mode     = m;
        exp_pass = 0;
        cyc      = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        checkOutput({tag, " busy@start"},  int'(busy),       1);
        checkOutput({tag, " done@start"},  int'(done),       0);
        checkOutput({tag, " count@start"}, int'(test_count), 0);
        for (int k = 0; k < NUM_TESTS; k++) begin
            for (int c = 1; c <= STEP; c++) begin
                cyc++;
                if (cyc == inject_at) start = 1'b1;
                tick();
                start = 1'b0;
                if (c < STEP) begin
                    checkOutput({tag, " early done"}, int'(done), 0);
                end
            end
            exp_pass += model_ok(m, model_bit(k));
            checkOutput({tag, " d"},          int'(d),          model_bit(k));
            checkOutput({tag, " test_count"}, int'(test_count), k + 1);
            checkOutput({tag, " pass_count"}, int'(pass_count), exp_pass);
            checkOutput({tag, " fail"},       int'(fail),       (exp_pass != k + 1) ? 1 : 0);
            checkOutput({tag, " busy"},       int'(busy),       (k < NUM_TESTS - 1) ? 1 : 0);
            checkOutput({tag, " done"},       int'(done),       (k == NUM_TESTS - 1) ? 1 : 0);
        end
        checkOutput({tag, " pass_out"}, int'(pass_out), (exp_pass == NUM_TESTS) ? 1 : 0);
    endtask

    initial begin
        int got_pass;

        vecs[0] = '{0, 8, 0, "ideal"};
`ifdef DFF_CHECKER_LFSR_EN
        vecs[1] = '{1, 3, 1, "q_stuck0"};
        vecs[2] = '{2, 5, 1, "q_stuck1"};
`else
        vecs[1] = '{1, 4, 1, "q_stuck0"};
        vecs[2] = '{2, 4, 1, "q_stuck1"};
`endif
        vecs[3] = '{3, 0, 1, "qn_eq_q"};

        reset = 1'b1;
        start = 1'b0;
        #2;
        checkIdleReset("reset");
        tick();
        reset = 1'b0;
        tick();
        checkIdleReset("post-reset idle");

        // Table of whole-run outcomes per fault mode.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].mode, -1, vecs[i].name, got_pass);
            checkOutput({vecs[i].name, " tbl test"},     int'(test_count), NUM_TESTS);
            checkOutput({vecs[i].name, " tbl pass"},     int'(pass_count), vecs[i].exp_pass);
            checkOutput({vecs[i].name, " tbl fail"},     int'(fail),       vecs[i].exp_fail);
            checkOutput({vecs[i].name, " tbl pass_out"}, int'(pass_out),   1 - vecs[i].exp_fail);
            tick();
            tick();
            checkOutput({vecs[i].name, " done held"}, int'(done), 1);
        end

        // Reset during the third check's WAIT phase, then a clean run.
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2 * STEP + 1; i++) tick();
        checkOutput("midrun busy before reset", int'(busy), 1);
        reset = 1'b1;
        #1;
        checkIdleReset("midrun reset");
        tick();
        reset = 1'b0;
        tick();
        checkIdleReset("after midrun reset");
        applyStimulus(0, -1, "post-reset run", got_pass);
        checkOutput("post-reset run pass", int'(pass_count), NUM_TESTS);

        // Start while busy is ignored; start in DONE restarts and clears.
        applyStimulus(1, 5, "busy restart", got_pass);
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart test_count", int'(test_count), 0);
        checkOutput("restart pass_count", int'(pass_count), 0);
        checkOutput("restart fail",       int'(fail),       0);
        checkOutput("restart done",       int'(done),       0);
        checkOutput("restart busy",       int'(busy),       1);
        for (int i = 0; i < NUM_TESTS * STEP - 1; i++) tick();
        checkOutput("restart not done early", int'(done), 0);
        tick();
        checkOutput("restart done at end", int'(done),       1);
        checkOutput("restart final pass",  int'(pass_count), NUM_TESTS);

        // Randomized runs: fault mode, idle gap and a stray busy start pulse.
        for (int r = 0; r < 6; r++) begin
            int m;
            int gap;
            int inj;
            m   = int'($urandom_range(0, 3));
            gap = int'($urandom_range(0, 4));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NUM_TESTS * STEP - 1)) : -1;
            for (int g = 0; g < gap; g++) tick();
            applyStimulus(m, inj, $sformatf("rand%0d m%0d", r, m), got_pass);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
